// File: rtl/config_shifter_pkg.sv
// Shared types and helpers for the serial configuration loader (config_shifter).
// FSM state encoding is fixed at 3 bits so it can be decoded from a waveform
// or by a bench without knowing the enum.
package config_shifter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ENABLE = 3'd2,
    ST_CLK_HI = 3'd3,
    ST_CLK_LO = 3'd4,
    ST_FINISH = 3'd5
  } cs_state_t;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/config_shifter_sclk_tick_gen.sv
// Phase timer for the serial clock: counts SCLK_DIV clk cycles per sclk phase
// and raises phase_end on the last cycle of each phase. restart holds the
// counter at zero so the first phase after it is a full SCLK_DIV cycles long.
module sclk_tick_gen #(
  parameter int SCLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase_end
);

  localparam int                CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SCLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running phase counter, reloaded on restart and at every phase boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign phase_end = (r_cnt == LAST);

endmodule

// File: rtl/config_shifter.sv
// config_shifter: loads one of NUM_PRESETS configuration words into a DUT over
// an enable/sclk/data serial link, LSB first, with sclk phases SCLK_DIV clk
// cycles long. Frames are started by a rising edge on `next` (walks the preset
// table) or by a `load` pulse (jumps to load_idx).
// Optional build macro: CFG_READBACK_EN -- captures cfg_sdo during the frame
// and raises a sticky mismatch flag when it differs from the word sent.
module config_shifter
  import config_shifter_pkg::*;
#(
  parameter int                             WIDTH       = 33,
  parameter int                             NUM_PRESETS = 8,
  parameter int                             IDX_W       = idx_width(NUM_PRESETS),
  parameter logic [NUM_PRESETS*WIDTH-1:0]   PRESETS     = '0,
  parameter int                             SCLK_DIV    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  output logic             cfg_enable,
  output logic             cfg_sclk,
  output logic             cfg_data,
  input  logic             cfg_sdo,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [IDX_W-1:0] preset_ptr
);

  localparam int               BIT_W    = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(NUM_PRESETS - 1);

  cs_state_t        r_state;
  logic             r_next_d;
  logic [WIDTH-1:0] r_shreg;
  logic             r_data;
  logic             r_enable;
  logic             r_sclk;
  logic             r_busy;
  logic             r_done;
  logic [BIT_W-1:0] r_bit;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_src;

  logic             w_next_rise;
  logic             w_trigger;
  logic [IDX_W-1:0] w_load_idx_c;
  logic [IDX_W-1:0] w_sel_idx;
  logic [WIDTH-1:0] w_preset;
  logic [IDX_W-1:0] w_ptr_inc;
  logic             w_phase_end;
  logic             w_restart;

  assign w_next_rise  = next & ~r_next_d;
  assign w_trigger    = load | w_next_rise;
  assign w_load_idx_c = (load_idx > MAX_IDX) ? MAX_IDX : load_idx;
  // load wins over a simultaneous next edge
  assign w_sel_idx    = load ? w_load_idx_c : r_ptr;
  assign w_preset     = PRESETS[int'(w_sel_idx)*WIDTH +: WIDTH];
  assign w_ptr_inc    = (r_src == MAX_IDX) ? '0 : r_src + 1'b1;
  // Phase counter runs only while sclk is toggling
  assign w_restart    = (r_state != ST_CLK_HI) && (r_state != ST_CLK_LO);

  sclk_tick_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .restart   (w_restart),
    .phase_end (w_phase_end)
  );

`ifdef CFG_READBACK_EN
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_word;
  logic             r_mismatch;
  assign mismatch = r_mismatch;
`else
  logic w_unused_sdo;
  assign w_unused_sdo = cfg_sdo;
  assign mismatch     = 1'b0;
`endif

  // Frame sequencer: trigger capture, sclk generation, bit shifting, pointer update.
  // cfg_data is a separate register that takes the next bit when sclk falls, so
  // the line is settled for a whole low phase before every rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_next_d   <= 1'b0;
      r_shreg    <= '0;
      r_data     <= 1'b0;
      r_enable   <= 1'b0;
      r_sclk     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bit      <= '0;
      r_ptr      <= '0;
      r_src      <= '0;
`ifdef CFG_READBACK_EN
      r_cap      <= '0;
      r_word     <= '0;
      r_mismatch <= 1'b0;
`endif
    end else begin
      r_next_d <= next;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_src   <= w_sel_idx;
            r_shreg <= w_preset;
            r_busy  <= 1'b1;
            r_state <= ST_SETUP;
`ifdef CFG_READBACK_EN
            r_word     <= w_preset;
            r_cap      <= '0;
            r_mismatch <= 1'b0;
`endif
          end
        end
        ST_SETUP: begin
          r_enable <= 1'b0;
          r_sclk   <= 1'b0;
          r_bit    <= '0;
          r_data   <= r_shreg[0];
          r_state  <= ST_ENABLE;
        end
        ST_ENABLE: begin
          r_enable <= 1'b1;
          r_sclk   <= 1'b1;
          r_state  <= ST_CLK_HI;
        end
        ST_CLK_HI: begin
          if (w_phase_end) begin
            r_sclk  <= 1'b0;
            r_data  <= r_shreg[1];
            r_state <= ST_CLK_LO;
`ifdef CFG_READBACK_EN
            r_cap <= {cfg_sdo, r_cap[WIDTH-1:1]};
`endif
          end
        end
        ST_CLK_LO: begin
          if (w_phase_end) begin
            r_shreg <= r_shreg >> 1;
            if (r_bit == LAST_BIT) begin
              r_enable <= 1'b0;
              r_state  <= ST_FINISH;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_sclk  <= 1'b1;
              r_state <= ST_CLK_HI;
            end
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_ptr   <= w_ptr_inc;
          r_state <= ST_IDLE;
`ifdef CFG_READBACK_EN
          if (r_cap != r_word) begin
            r_mismatch <= 1'b1;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_enable = r_enable;
  assign cfg_sclk   = r_sclk;
  assign cfg_data   = r_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign preset_ptr = r_ptr;

endmodule

// File: tb/tb_config_shifter.sv
// Scoreboard bench for config_shifter. Two instances share reset: dut0 with
// SCLK_DIV=1 and dut1 with SCLK_DIV=4. Stimulus pushes the expected frame into
// a per-instance queue; a monitor reassembles each frame from sclk/data and
// compares it when done pulses. Readback tests need CFG_READBACK_EN.
module tb_config_shifter;

  localparam logic [32:0] P0 = 33'h0_3CF1_0404;
  localparam logic [32:0] P1 = 33'h1_2345_6789;
  localparam logic [32:0] P2 = 33'h0_DEAD_BEEF;
  localparam logic [32:0] P3 = 33'h1_FFFF_FFFF;
  localparam logic [32:0] P4 = 33'h0_0000_0001;
  localparam logic [32:0] P5 = 33'h1_5555_AAAA;
  localparam logic [32:0] P6 = 33'h0_8000_0000;
  localparam logic [32:0] P7 = 33'h1_0F0F_F0F0;
  localparam logic [8*33-1:0] PRESETS = {P7, P6, P5, P4, P3, P2, P1, P0};
  localparam int BUSY_LEN [2] = '{69, 267};
  localparam int DIV      [2] = '{1, 4};

  typedef struct {
    logic [32:0] word;
    logic [2:0]  ptr;
    logic        mism;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] next_w = '0;
  logic [1:0] load_w = '0;
  logic [2:0] load_idx_w [2] = '{3'd0, 3'd0};
  logic [1:0] en_w, sclk_w, data_w, sdo_w, busy_w, done_w, mism_w;
  logic [2:0] ptr_w [2];

  int   checks = 0;
  int   errors = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  int   exp_ptr0 = 0;
  bit   flip7 = 1'b0;

  int          mon_nb   [2];
  int          mon_bc   [2];
  int          mon_hi   [2];
  int          mon_lo   [2];
  int          mon_bad  [2];
  int          done_cnt [2];
  logic [32:0] mon_rx   [2];
  logic [1:0]  prev_sclk;
  logic [1:0]  prev_data;

  always #5 clk = ~clk;

  // DUT echoes its data back; optionally corrupt bit 7 of dut0's readback
  assign sdo_w[0] = data_w[0] ^ (flip7 && (mon_nb[0] == 8));
  assign sdo_w[1] = data_w[1];

  config_shifter #(.WIDTH(33), .NUM_PRESETS(8), .PRESETS(PRESETS), .SCLK_DIV(1)) dut0 (
    .clk(clk), .reset(rst), .next(next_w[0]), .load(load_w[0]), .load_idx(load_idx_w[0]),
    .cfg_enable(en_w[0]), .cfg_sclk(sclk_w[0]), .cfg_data(data_w[0]), .cfg_sdo(sdo_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .mismatch(mism_w[0]), .preset_ptr(ptr_w[0])
  );

  config_shifter #(.WIDTH(33), .NUM_PRESETS(8), .PRESETS(PRESETS), .SCLK_DIV(4)) dut1 (
    .clk(clk), .reset(rst), .next(next_w[1]), .load(load_w[1]), .load_idx(load_idx_w[1]),
    .cfg_enable(en_w[1]), .cfg_sclk(sclk_w[1]), .cfg_data(data_w[1]), .cfg_sdo(sdo_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .mismatch(mism_w[1]), .preset_ptr(ptr_w[1])
  );

  function automatic logic [32:0] preset_word(input int i);
    case (i)
      0: return P0;  1: return P1;  2: return P2;  3: return P3;
      4: return P4;  5: return P5;  6: return P6;  default: return P7;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_next0(input logic mism);
    exp_t e;
    e.word = preset_word(exp_ptr0);
    e.ptr  = 3'((exp_ptr0 + 1) % 8);
    e.mism = mism;
    q0.push_back(e);
    exp_ptr0 = (exp_ptr0 + 1) % 8;
  endtask

  task automatic trig_next(input int d);
    @(posedge clk); #1 next_w[d] = 1'b1;
    @(posedge clk); #1 next_w[d] = 1'b0;
  endtask

  task automatic trig_load(input int d, input logic [2:0] idx);
    @(posedge clk); #1 load_w[d] = 1'b1; load_idx_w[d] = idx;
    @(posedge clk); #1 load_w[d] = 1'b0;
  endtask

  task automatic wait_frame(input int d);
    int start;
    bit got;
    start = done_cnt[d];
    got   = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(posedge clk);
      if (done_cnt[d] != start) got = 1'b1;
    end
    check("frame_done_seen", 64'(got), 64'(1));
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: rebuild frames from the serial pins and score them on done
  initial begin
    for (int d = 0; d < 2; d++) begin
      mon_nb[d] = 0; mon_bc[d] = 0; mon_hi[d] = 0; mon_lo[d] = 0;
      mon_bad[d] = 0; done_cnt[d] = 0; mon_rx[d] = '0;
    end
    prev_sclk = '0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          mon_nb[d] = 0; mon_bc[d] = 0; mon_hi[d] = 0; mon_lo[d] = 0;
          mon_bad[d] = 0; mon_rx[d] = '0; prev_sclk[d] = 1'b0;
          continue;
        end
        if (busy_w[d]) mon_bc[d]++;
        if (sclk_w[d] && !prev_sclk[d]) begin
          if (!en_w[d]) mon_bad[d]++;
          if (mon_nb[d] > 0 && mon_lo[d] != DIV[d]) mon_bad[d]++;
          if (mon_nb[d] < 33) mon_rx[d][mon_nb[d]] = data_w[d];
          mon_nb[d]++;
          mon_hi[d] = 0;
        end
        if (!sclk_w[d] && prev_sclk[d]) begin
          if (mon_hi[d] != DIV[d]) mon_bad[d]++;
          mon_lo[d] = 0;
        end
        if (sclk_w[d] && prev_sclk[d] && (data_w[d] != prev_data[d])) mon_bad[d]++;
        if (sclk_w[d]) mon_hi[d]++;
        else           mon_lo[d]++;
        prev_sclk[d] = sclk_w[d];
        prev_data[d] = data_w[d];
        if (done_w[d]) begin
          exp_t e;
          bit   have;
          have = 1'b0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut%0d actual=frame expected=none", d);
          end else begin
            $display("frame dut%0d word=%h bits=%0d busy=%0d ptr=%0d mism=%0b",
                     d, mon_rx[d], mon_nb[d], mon_bc[d], ptr_w[d], mism_w[d]);
            check("word",       64'(mon_rx[d]),  64'(e.word));
            check("sclk_rises", 64'(mon_nb[d]),  64'(33));
            check("busy_len",   64'(mon_bc[d]),  64'(BUSY_LEN[d]));
            check("ptr_after",  64'(ptr_w[d]),   64'(e.ptr));
            check("mismatch",   64'(mism_w[d]),  64'(e.mism));
            check("sclk_shape", 64'(mon_bad[d]), 64'(0));
          end
          done_cnt[d]++;
          mon_nb[d] = 0; mon_bc[d] = 0; mon_bad[d] = 0; mon_rx[d] = '0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int dc;
    bit hit;
    repeat (3) @(posedge clk);
    #1;
    check("rst_enable", 64'(en_w[0]),   64'(0));
    check("rst_sclk",   64'(sclk_w[0]), 64'(0));
    check("rst_data",   64'(data_w[0]), 64'(0));
    check("rst_busy",   64'(busy_w[0]), 64'(0));
    check("rst_done",   64'(done_w[0]), 64'(0));
    check("rst_mism",   64'(mism_w[0]), 64'(0));
    check("rst_ptr",    64'(ptr_w[0]),  64'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Walk all eight presets with next edges (ptr wraps 7->0), then a ninth
    for (int k = 0; k < 9; k++) begin
      push_next0(1'b0);
      trig_next(0);
      wait_frame(0);
    end

    // Slow-sclk instance: 4-cycle phases, 267-cycle frame
    q1.push_back('{word: P0, ptr: 3'd1, mism: 1'b0});
    trig_next(1);
    wait_frame(1);

    // load beats a simultaneous next edge; triggers during busy are dropped
    q0.push_back('{word: P5, ptr: 3'd6, mism: 1'b0});
    @(posedge clk); #1 next_w[0] = 1'b1; load_w[0] = 1'b1; load_idx_w[0] = 3'd5;
    @(posedge clk); #1 next_w[0] = 1'b0; load_w[0] = 1'b0;
    repeat (6) @(posedge clk);
    trig_next(0);
    trig_load(0, 3'd2);
    wait_frame(0);
    dc = done_cnt[0];
    repeat (100) @(posedge clk);
    #1;
    check("no_extra_frame", 64'(done_cnt[0]), 64'(dc));
    check("idle_busy",      64'(busy_w[0]),   64'(0));
    exp_ptr0 = 6;

    // load of the last index wraps the pointer to 0
    q0.push_back('{word: P7, ptr: 3'd0, mism: 1'b0});
    trig_load(0, 3'd7);
    wait_frame(0);
    exp_ptr0 = 0;
    push_next0(1'b0);
    trig_next(0);
    wait_frame(0);

    // Reset in the middle of a frame (ptr is 1 here)
    push_next0(1'b0);
    trig_next(0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (mon_nb[0] == 10) hit = 1'b1;
    end
    check("reached_bit10", 64'(hit), 64'(1));
    dc = done_cnt[0];
    #2 rst = 1'b1;
    #1;
    check("abort_enable", 64'(en_w[0]),   64'(0));
    check("abort_sclk",   64'(sclk_w[0]), 64'(0));
    check("abort_busy",   64'(busy_w[0]), 64'(0));
    check("abort_ptr",    64'(ptr_w[0]),  64'(0));
    void'(q0.pop_back());
    exp_ptr0 = 0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt[0]), 64'(dc));
    check("abort_ptr_held", 64'(ptr_w[0]), 64'(0));

`ifdef CFG_READBACK_EN
    // Readback: clean loop, corrupted bit 7, then cleared on next frame start
    push_next0(1'b0);
    trig_next(0);
    wait_frame(0);
    flip7 = 1'b1;
    push_next0(1'b1);
    trig_next(0);
    wait_frame(0);
    flip7 = 1'b0;
    check("mism_sticky", 64'(mism_w[0]), 64'(1));
    push_next0(1'b0);
    trig_next(0);
    check("mism_cleared", 64'(mism_w[0]), 64'(0));
    wait_frame(0);
`endif

    check("queue_drained", 64'(q0.size() + q1.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
